// File: rtl/bpsk_demodulator_if.sv
// Sample-in / decision-out bundle for the BPSK receive back-end.
// master drives samples and consumes decisions; slave is the demodulator.
interface bpsk_demodulator_if #(
    parameter int SW = 12
);
    logic [15:0]          symbol_len;
    logic                 rx_valid;
    logic signed [SW-1:0] rx_sample;
    logic                 ref_sign;
    logic                 bit_valid;
    logic                 bit_out;
    logic                 locked;
    logic                 byte_valid;
    logic [7:0]           byte_out;
    logic                 frame_done;

    modport master (
        output symbol_len, rx_valid, rx_sample, ref_sign,
        input  bit_valid, bit_out, locked, byte_valid, byte_out, frame_done
    );

    modport slave (
        input  symbol_len, rx_valid, rx_sample, ref_sign,
        output bit_valid, bit_out, locked, byte_valid, byte_out, frame_done
    );
endinterface

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK integrate-and-dump slicer with sync-word hunt (either polarity)
// and fixed-length payload byte assembly.
module bpsk_demodulator #(
    parameter int          SW            = 12,
    parameter int          ACC_W         = SW + 16,
    parameter logic [15:0] SYNC_WORD     = 16'hA5F0,
    parameter int          PAYLOAD_BYTES = 4
) (
    input  logic                  mCLK,
    input  logic                  rst,
    bpsk_demodulator_if.slave     bus
);
    typedef enum logic {HUNT, DATA} state_t;

    state_t                   state, state_n;
    logic signed [ACC_W-1:0]  acc, acc_n;
    logic [15:0]              cnt, cnt_n, len_q, len_n;
    logic [15:0]              sr, sr_n;
    logic                     inv, inv_n;
    logic [7:0]               byte_sr, byte_sr_n;
    logic [2:0]               bit_cnt, bit_cnt_n;
    logic [7:0]               byte_cnt, byte_cnt_n;

    logic                     bit_valid_q, bit_valid_n;
    logic                     bit_out_q, bit_out_n;
    logic                     locked_q, locked_n;
    logic                     byte_valid_q, byte_valid_n;
    logic [7:0]               byte_out_q, byte_out_n;
    logic                     frame_done_q, frame_done_n;

    logic signed [SW:0]       ext, prod;
    logic signed [ACC_W-1:0]  sum;
    logic [15:0]              len_eff, len_cur;
    logic                     sym_done, decision, d;

    // One extra bit so negating the most negative sample cannot overflow.
    assign ext  = {bus.rx_sample[SW-1], bus.rx_sample};
    assign prod = bus.ref_sign ? ext : -ext;
    assign sum  = acc + {{(ACC_W-SW-1){prod[SW]}}, prod};

    assign len_eff  = (bus.symbol_len < 16'd2) ? 16'd2 : bus.symbol_len;
    // At a symbol boundary the length being latched this cycle already governs.
    assign len_cur  = (cnt == 16'd0) ? len_eff : len_q;
    assign sym_done = bus.rx_valid && (cnt == len_cur - 16'd1);
    assign decision = !sum[ACC_W-1] && (sum != '0);
    assign d        = decision ^ inv;

    always_ff @(posedge mCLK) begin
        if (rst) begin
            state        <= HUNT;
            acc          <= '0;
            cnt          <= '0;
            len_q        <= '0;
            sr           <= '0;
            inv          <= 1'b0;
            byte_sr      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            bit_valid_q  <= 1'b0;
            bit_out_q    <= 1'b0;
            locked_q     <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_out_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            cnt          <= cnt_n;
            len_q        <= len_n;
            sr           <= sr_n;
            inv          <= inv_n;
            byte_sr      <= byte_sr_n;
            bit_cnt      <= bit_cnt_n;
            byte_cnt     <= byte_cnt_n;
            bit_valid_q  <= bit_valid_n;
            bit_out_q    <= bit_out_n;
            locked_q     <= locked_n;
            byte_valid_q <= byte_valid_n;
            byte_out_q   <= byte_out_n;
            frame_done_q <= frame_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        acc_n        = acc;
        cnt_n        = cnt;
        len_n        = len_q;
        sr_n         = sr;
        inv_n        = inv;
        byte_sr_n    = byte_sr;
        bit_cnt_n    = bit_cnt;
        byte_cnt_n   = byte_cnt;
        bit_valid_n  = 1'b0;
        bit_out_n    = bit_out_q;
        byte_valid_n = 1'b0;
        byte_out_n   = byte_out_q;
        frame_done_n = 1'b0;

        if (cnt == 16'd0)
            len_n = len_eff;

        if (bus.rx_valid) begin
            if (sym_done) begin
                acc_n       = '0;
                cnt_n       = '0;
                bit_valid_n = 1'b1;
                bit_out_n   = decision;
                case (state)
                    HUNT: begin
                        sr_n = {sr[14:0], decision};
                        if (sr_n == SYNC_WORD || sr_n == ~SYNC_WORD) begin
                            state_n    = DATA;
                            inv_n      = (sr_n != SYNC_WORD);
                            bit_cnt_n  = '0;
                            byte_cnt_n = '0;
                        end
                    end
                    DATA: begin
                        byte_sr_n = {byte_sr[6:0], d};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_valid_n = 1'b1;
                            byte_out_n   = byte_sr_n;
                            byte_cnt_n   = byte_cnt + 8'd1;
                            if (byte_cnt == 8'(PAYLOAD_BYTES - 1)) begin
                                frame_done_n = 1'b1;
                                state_n      = HUNT;
                                sr_n         = '0;
                                inv_n        = 1'b0;
                                byte_cnt_n   = '0;
                            end
                        end
                    end
                    default: state_n = HUNT;
                endcase
            end else begin
                acc_n = sum;
                cnt_n = cnt + 16'd1;
            end
        end

        // Held through the frame_done cycle so the drop lands one cycle later.
        locked_n = (state_n == DATA) || frame_done_n;
    end

    assign bus.bit_valid  = bit_valid_q;
    assign bus.bit_out    = bit_out_q;
    assign bus.locked     = locked_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_out   = byte_out_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed bench for bpsk_demodulator: slicer vectors, length extremes,
// normal/inverted frames and reset in mid-frame.
module tb_bpsk_demodulator;
    logic mCLK = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bpsk_demodulator_if #(.SW(12)) bus ();

    bpsk_demodulator dut (
        .mCLK (mCLK),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 mCLK = ~mCLK;

    typedef struct {
        logic [15:0]      len;
        logic             rs;
        logic [3:0][11:0] smp;
        logic             exp_bit;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [3:0][11:0] mk(input int a, input int b, input int c, input int e);
        logic [3:0][11:0] r;
        r[0] = a[11:0];
        r[1] = b[11:0];
        r[2] = c[11:0];
        r[3] = e[11:0];
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, let the edge pass, then settle for sampling.
    task automatic step(input logic v, input int s, input logic r);
        bus.rx_valid  = v;
        bus.rx_sample = s[11:0];
        bus.ref_sign  = r;
        @(posedge mCLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        for (int k = 0; k < 4; k++)
            step(1'b1, b ? 100 : -100, 1'b1);
    endtask

    task automatic run_frame(input logic inv, input int nbits);
        logic [47:0] stream;
        logic [47:0] sh;
        logic        b;
        stream = {16'hA5F0, 32'h12345678};
        for (int i = 0; i < nbits; i++) begin
            b = stream[47-i] ^ inv;
            send_bit(b);
            chk("frm_bit_valid", int'(bus.bit_valid), 1);
            chk("frm_bit_out", int'(bus.bit_out), int'(b));
            chk("frm_locked", int'(bus.locked), (i < 15) ? 0 : 1);
            if (i >= 16 && ((i - 16) % 8) == 7) begin
                sh = stream >> (47 - i);
                chk("frm_byte_valid", int'(bus.byte_valid), 1);
                chk("frm_byte_out", int'(bus.byte_out), int'(sh[7:0]));
                chk("frm_frame_done", int'(bus.frame_done), (i == 47) ? 1 : 0);
            end else begin
                chk("frm_byte_valid_idle", int'(bus.byte_valid), 0);
                chk("frm_frame_done_idle", int'(bus.frame_done), 0);
            end
        end
        if (nbits == 48) begin
            step(1'b0, 0, 1'b1);
            chk("frm_locked_fall", int'(bus.locked), 0);
            chk("frm_fd_pulse", int'(bus.frame_done), 0);
            chk("frm_bv_pulse", int'(bus.byte_valid), 0);
            chk("frm_byte_hold", int'(bus.byte_out), 8'h78);
        end
    endtask

    initial begin
        int early;
        int nbv;

        vecs[0] = '{16'd4, 1'b1, mk(100, 100, 100, 100), 1'b1};
        vecs[1] = '{16'd4, 1'b1, mk(-100, -100, -100, -100), 1'b0};
        vecs[2] = '{16'd4, 1'b1, mk(5, -5, 5, -5), 1'b0};
        vecs[3] = '{16'd4, 1'b0, mk(-100, -100, -100, -100), 1'b1};
        vecs[4] = '{16'd3, 1'b0, mk(50, -20, -40, 0), 1'b1};
        vecs[5] = '{16'd4, 1'b1, mk(-2048, 2047, 1, 0), 1'b0};
        vecs[6] = '{16'd4, 1'b1, mk(-10, -10, -10, 31), 1'b1};

        bus.symbol_len = 16'd4;
        bus.rx_valid   = 1'b0;
        bus.rx_sample  = '0;
        bus.ref_sign   = 1'b1;

        // Reset with live traffic: nothing may come out.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(i[0] == 1'b0, 500, 1'b1);
            chk("rst_outputs", int'({bus.bit_valid, bus.bit_out, bus.locked,
                                     bus.byte_valid, bus.byte_out, bus.frame_done}), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 100, 1'b1);
            chk("post_rst_no_bit", int'(bus.bit_valid), 0);
        end
        step(1'b1, 100, 1'b1);
        chk("post_rst_first_bit", int'(bus.bit_valid), 1);
        chk("post_rst_bit_out", int'(bus.bit_out), 1);
        step(1'b0, 0, 1'b1);

        // Slicer vectors.
        foreach (vecs[v]) begin
            bus.symbol_len = vecs[v].len;
            for (int j = 0; j < int'(vecs[v].len); j++) begin
                step(1'b1, int'($signed(vecs[v].smp[j])), vecs[v].rs);
                if (j < int'(vecs[v].len) - 1)
                    chk("vec_mid_bv", int'(bus.bit_valid), 0);
            end
            chk("vec_bv", int'(bus.bit_valid), 1);
            chk("vec_bit", int'(bus.bit_out), int'(vecs[v].exp_bit));
            step(1'b0, 0, 1'b1);
            chk("vec_pulse_end", int'(bus.bit_valid), 0);
        end

        // Longest symbol at full negative scale.
        bus.symbol_len = 16'd65535;
        early = 0;
        for (int i = 0; i < 65535; i++) begin
            step(1'b1, -2048, 1'b1);
            if (i < 65534 && bus.bit_valid) early++;
        end
        chk("ext_early_bits", early, 0);
        chk("ext_bv", int'(bus.bit_valid), 1);
        chk("ext_bit_neg", int'(bus.bit_out), 0);

        // Gapped input, inverted reference.
        bus.symbol_len = 16'd3000;
        early = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1'b1, -2048, 1'b0);
            if (i < 2999 && bus.bit_valid) early++;
            if (i == 2999) begin
                chk("gap_bv", int'(bus.bit_valid), 1);
                chk("gap_bit_pos", int'(bus.bit_out), 1);
            end
            step(1'b0, 2047, 1'b1);
            if (bus.bit_valid) early++;
            step(1'b0, 2047, 1'b1);
            if (bus.bit_valid) early++;
        end
        chk("gap_stray_bits", early, 0);

        // symbol_len 0 and 1 both mean 2.
        for (int l = 0; l < 2; l++) begin
            bus.symbol_len = 16'(l);
            nbv = 0;
            for (int i = 0; i < 6; i++) begin
                step(1'b1, 100, 1'b1);
                chk("short_len_bv", int'(bus.bit_valid), i % 2);
                nbv += int'(bus.bit_valid);
            end
            chk("short_len_count", nbv, 3);
        end
        step(1'b0, 0, 1'b1);

        // Frames.
        bus.symbol_len = 16'd4;
        do_reset();
        run_frame(1'b0, 48);
        run_frame(1'b1, 48);

        // Reset after the second payload byte.
        run_frame(1'b0, 32);
        rst = 1'b1;
        step(1'b0, 0, 1'b1);
        rst = 1'b0;
        chk("midrst_locked", int'(bus.locked), 0);
        chk("midrst_byte_out", int'(bus.byte_out), 0);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] rest;
            rest = 16'h5678;
            send_bit(rest[15-i]);
            chk("midrst_no_byte", int'(bus.byte_valid), 0);
            chk("midrst_no_lock", int'(bus.locked), 0);
        end
        run_frame(1'b0, 48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bpsk_demodulator.md
# bpsk_demodulator

Coherent BPSK receiver back-end: the receive-side counterpart of the BPSK controller/modulator chain. It multiplies each incoming baseband sample by the local ±1 carrier reference and integrates-and-dumps over a programmable symbol period to slice hard bits. It hunts for a 16-bit frame sync word in either polarity, resolving the 180° phase ambiguity. After lock it assembles a fixed-length payload into bytes for the controller.

## Interface
- SW, 12, rx_sample width (two's complement)
- ACC_W, SW+16, integrator width; must be ≥ SW+17 bits of headroom minus 1, i.e. sized for 65535 × 2^(SW-1)
- SYNC_WORD, 16'hA5F0, frame sync pattern, MSB sent first
- PAYLOAD_BYTES, 4, bytes per frame after sync (1..255)

Ports:
- mCLK  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- symbol_len  in  16  samples per symbol; values 0 and 1 are treated as 2
- rx_valid  in  1  qualifies rx_sample/ref_sign this cycle
- rx_sample  in  SW  signed baseband sample
- ref_sign  in  1  local carrier reference: 1 = +1, 0 = −1
- bit_valid  out  1  one-cycle pulse, new decision on bit_out
- bit_out  out  1  raw sliced bit (before polarity correction)
- locked  out  1  high while in DATA state
- byte_valid  out  1  one-cycle pulse, byte_out valid
- byte_out  out  8  payload byte, MSB first on air, polarity-corrected
- frame_done  out  1  one-cycle pulse with last payload byte

## Operation
- Product: p = ref_sign ? rx_sample : −rx_sample, computed in SW+1 bits, so −2^(SW-1) negates without overflow.
- Integrator: on each rx_valid cycle, acc += p and sample counter increments.
  - symbol_len is latched into len_q when the counter is 0.
  - When counter == len_q−1 with rx_valid, the symbol completes: sum = acc + p; decision = (sum > 0); acc ← 0; counter ← 0.
  - A sum of exactly 0 decides 0.
- rx_valid low: integrator, counter and FSM hold; all pulse outputs are 0.
- FSM states HUNT and DATA, advanced only on symbol completion:
  - HUNT: sr ← {sr[14:0], decision}.
    - If the new sr == SYNC_WORD: go to DATA with inv=0.
    - Else if the new sr == ~SYNC_WORD: go to DATA with inv=1.
    - Else stay in HUNT.
  - DATA: d = decision ^ inv is shifted into the byte register MSB first.
    - On the 8th bit, byte_valid pulses, byte_out = assembled byte, and the byte count increments.
    - On byte PAYLOAD_BYTES, frame_done pulses with that byte_valid, and the next state is HUNT with sr ← 0 and inv ← 0.
- Sync cannot be detected inside a payload. Sync search restarts from a cleared sr after every frame.
- Reset, including mid-frame: acc, counter, len_q, sr, inv, bit and byte counts cleared; state HUNT; all outputs 0; a partial frame is dropped silently.

## Timing
- Reset values: bit_valid=0, bit_out=0, locked=0, byte_valid=0, byte_out=8'h00, frame_done=0.
- All outputs are registered.
- bit_valid/bit_out: one cycle after the rx_valid cycle carrying the symbol's last sample. Latency 1 cycle; pulse width 1 cycle.
- locked rises in the same cycle as bit_valid of the 16th sync bit.
- byte_valid rises in the same cycle as bit_valid of each byte's 8th bit.
- frame_done coincides with the final byte_valid. locked falls in the following cycle.
- Back-to-back symbols with rx_valid held high give bit_valid every len_q cycles (minimum every 2 cycles).
- symbol_len changes mid-symbol take effect at the next symbol boundary.
- byte_out holds its value between byte_valid pulses.

## Test plan
- Reset: rst=1 for 3 cycles while rx_valid toggles with nonzero samples → all outputs 0, no pulses; after release, the first bit appears only after a full symbol_len samples.
- Slicer, symbol_len=4, ref_sign=1:
  - samples +100×4 → bit_valid 1 cycle after the 4th sample, bit_out=1.
  - −100×4 → 0.
  - +5,−5,+5,−5 → 0.
  - ref_sign=0 with −100×4 → 1.
- Extremes: symbol_len=65535, rx_sample=−2048, ref_sign=1 → bit_out=0, with rx_valid gapped 1-in-3 cycles (no overflow). ref_sign=0 → bit_out=1. symbol_len=0 → bit_valid every 2 valid samples.
- Frame: symbol_len=4, bits of 0xA5F0 then 0x12,0x34,0x56,0x78:
  - locked rises with the 16th sync bit.
  - byte_valid ×4 with those values.
  - frame_done with 0x78; locked=0 on the next cycle.
- Inverted frame: bitwise complement of the entire frame stream → same locked timing, bytes 0x12,0x34,0x56,0x78.
- Reset mid-frame after byte 0x34: rst 1 cycle → locked=0, no further byte_valid. A following full frame decodes 0x12,0x34,0x56,0x78 correctly.
